// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one start/done serial multiplier among NUM_REQ requesters.
// Define MUL_TIMEOUT_EN to build the WAIT-state watchdog that drives err_o; otherwise err_o is tied low.
module mul_arbiter #(
  parameter int unsigned OP_BITWIDTH    = 82,
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [NUM_REQ*OP_BITWIDTH-1:0] a_i,
  input  logic [NUM_REQ*OP_BITWIDTH-1:0] b_i,
  output logic [NUM_REQ-1:0]             grant_o,
  output logic [NUM_REQ-1:0]             done_o,
  output logic [OP_BITWIDTH-1:0]         result_o,
  output logic                           busy_o,
  output logic                           ovf_o,
  output logic                           err_o,
  output logic                           mul_start_strb_o,
  output logic [OP_BITWIDTH-1:0]         mul_a_o,
  output logic [OP_BITWIDTH-1:0]         mul_b_o,
  input  logic                           mul_done_strb_i,
  input  logic [OP_BITWIDTH-1:0]         mul_out_i
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    DONE
  } state_e;

  state_e                 state_q;
  logic [NUM_REQ-1:0]     pend_q;
  logic [IW-1:0]          last_q;
  logic [IW-1:0]          gidx_q;

  logic                   sel_vld;
  logic [IW-1:0]          sel_idx;
  logic [NUM_REQ-1:0]     sel_oh;
  logic [OP_BITWIDTH-1:0] sel_a;
  logic [OP_BITWIDTH-1:0] sel_b;
  logic [NUM_REQ-1:0]     pend_clr;
  int unsigned            scan_idx;

`ifdef MUL_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_q;
`else
  logic unused_tmo;
  assign unused_tmo = |TIMEOUT_CYCLES;
  assign err_o      = 1'b0;
`endif

  // Scan last_q+1, last_q+2, ... (mod NUM_REQ); the first pending index wins.
  always_comb begin
    sel_vld  = 1'b0;
    sel_idx  = '0;
    sel_oh   = '0;
    sel_a    = '0;
    sel_b    = '0;
    scan_idx = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      scan_idx = (32'(last_q) + i) % NUM_REQ;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (!sel_vld && (k == scan_idx) && pend_q[k]) begin
          sel_vld   = 1'b1;
          sel_idx   = IW'(k);
          sel_oh[k] = 1'b1;
          sel_a     = a_i[k*OP_BITWIDTH +: OP_BITWIDTH];
          sel_b     = b_i[k*OP_BITWIDTH +: OP_BITWIDTH];
        end
      end
    end
  end

  assign pend_clr = (state_q == IDLE) ? sel_oh : '0;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q          <= IDLE;
      pend_q           <= '0;
      last_q           <= IW'(NUM_REQ - 1);
      gidx_q           <= '0;
      grant_o          <= '0;
      done_o           <= '0;
      result_o         <= '0;
      busy_o           <= 1'b0;
      ovf_o            <= 1'b0;
      mul_start_strb_o <= 1'b0;
      mul_a_o          <= '0;
      mul_b_o          <= '0;
`ifdef MUL_TIMEOUT_EN
      err_o            <= 1'b0;
      tmo_q            <= '0;
`endif
    end else begin
      // A request in its own grant cycle re-queues: the set term is ORed after the clear.
      pend_q <= (pend_q & ~pend_clr) | req_i;
      if (|(req_i & pend_q)) begin
        ovf_o <= 1'b1;
      end
      done_o           <= '0;
      mul_start_strb_o <= 1'b0;
`ifdef MUL_TIMEOUT_EN
      err_o            <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (sel_vld) begin
            gidx_q           <= sel_idx;
            grant_o          <= sel_oh;
            mul_a_o          <= sel_a;
            mul_b_o          <= sel_b;
            mul_start_strb_o <= 1'b1;
            busy_o           <= 1'b1;
            state_q          <= START;
          end
        end
        START: begin
`ifdef MUL_TIMEOUT_EN
          tmo_q   <= '0;
`endif
          state_q <= WAIT;
        end
        WAIT: begin
          if (mul_done_strb_i) begin
            result_o <= mul_out_i;
            done_o   <= grant_o;
            state_q  <= DONE;
`ifdef MUL_TIMEOUT_EN
          end else if (tmo_q == CW'(TIMEOUT_CYCLES - 1)) begin
            result_o <= '0;
            done_o   <= grant_o;
            err_o    <= 1'b1;
            state_q  <= DONE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
`endif
          end
        end
        DONE: begin
          last_q  <= gidx_q;
          grant_o <= '0;
          busy_o  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mul_arbiter.md
Name: mul_arbiter

Overview:
- Shares one serial multiplier (BIT_MUL start/done strobe interface) between up to four requesters, e.g. PID_core and a further filter or scaling stage.
- Queues single-cycle request strobes, grants the multiplier round-robin and registers operands on grant.
- Returns the product on a shared result bus with a per-requester done strobe.
- Sits between the requesting datapaths and the single BIT_MUL instance.

Parameters:
- OP_BITWIDTH, 82, width of each operand and of the product (2 × multiplier N).
- NUM_REQ, 2, number of requesters, legal range 1..4.
- TIMEOUT_CYCLES, 4096, watchdog limit in clocks; used only with MUL_TIMEOUT_EN.

Ports:
- clk_i  in  1  system clock.
- rstn_i  in  1  asynchronous active-low reset.
- req_i  in  NUM_REQ  one-cycle request strobe per requester.
- a_i  in  NUM_REQ*OP_BITWIDTH  packed operand A; requester k at slice [k*OP_BITWIDTH +: OP_BITWIDTH].
- b_i  in  NUM_REQ*OP_BITWIDTH  packed operand B; same packing as a_i.
- grant_o  out  NUM_REQ  one-hot; owner of the multiplier from START through DONE.
- done_o  out  NUM_REQ  one-cycle strobe to the owner when result_o is valid.
- result_o  out  OP_BITWIDTH  signed product of the last completed operation.
- busy_o  out  1  high when the FSM is not in IDLE.
- ovf_o  out  1  sticky flag: a request arrived while the same requester was already pending.
- err_o  out  1  qualifies done_o: high means the operation timed out (MUL_TIMEOUT_EN only, else tied 0).
- mul_start_strb_o  out  1  start strobe to the multiplier.
- mul_a_o  out  OP_BITWIDTH  operand A to the multiplier.
- mul_b_o  out  OP_BITWIDTH  operand B to the multiplier.
- mul_done_strb_i  in  1  done strobe from the multiplier.
- mul_out_i  in  OP_BITWIDTH  product from the multiplier.

Behaviour:
- Reset: asynchronous, active-low. On reset:
  - all outputs, pending flags, operand registers and result register go to 0;
  - the round-robin pointer last_q goes to NUM_REQ-1, so requester 0 has first priority;
  - the FSM goes to IDLE.
- Reset mid-operation discards the operation; no done_o is issued.
- Pending flags:
  - req_i[k] sets pend[k] at the clock edge.
  - Granting k clears pend[k].
  - If req_i[k] arrives in the same cycle as the grant to k, set wins and a new request stays queued.
  - If req_i[k] arrives while pend[k] is already 1, set ovf_o=1. ovf_o clears only on reset.
- FSM states: IDLE, START, WAIT, DONE.
- IDLE:
  - If any pend is set, select the first set index scanning last_q+1, last_q+2, ... (mod NUM_REQ).
  - Latch g=index, mul_a_o=a_i[g] and mul_b_o=b_i[g] from the current input values; set grant_o one-hot; go to START.
  - If no pend is set, stay in IDLE.
- START:
  - mul_start_strb_o=1 for exactly this one cycle; go to WAIT.
  - Operands stay stable from START until DONE exits; requesters may change a_i/b_i freely after the grant.
- WAIT:
  - On mul_done_strb_i=1, latch result_o=mul_out_i and go to DONE.
  - mul_done_strb_i in any state other than WAIT is ignored.
- DONE:
  - done_o[g]=1 for one cycle; last_q=g.
  - grant_o clears on exit; go to IDLE.
- Latency:
  - req_i at edge E0 → START cycle after E1 → mul_start_strb_o high between E1 and E2.
  - With a multiplier latency of L cycles from start to done, done_o is high L+2 cycles after the start strobe.
  - Minimum spacing between back-to-back grants is 4 cycles plus L.
- result_o holds its value until the next completion.
- busy_o=1 in START, WAIT and DONE.
- NUM_REQ=1: arbitration degenerates; requester 0 is always granted.

Optional Feature:
- Macro: MUL_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT.
  - If it reaches TIMEOUT_CYCLES without mul_done_strb_i, go to DONE with result_o=0 and err_o=1 coincident with done_o.
  - err_o is 0 on normal completions.
- Not defined:
  - No counter is built; WAIT waits indefinitely.
  - err_o is constant 0.

Test Plan:
1. Reset then single request: req_i=01, a=3, b=-5, multiplier model L=10 → exactly one mul_start_strb_o pulse; grant_o=01; done_o=01 twelve cycles after the start strobe; result_o=-15.
2. Simultaneous requests: req_i=11 after reset → requester 0 served first, then requester 1 without a new request; next simultaneous pair → order is 0,1 again, since last_q=1.
3. Operand hold: change a_i[0] to 7 one cycle after grant → product still uses the latched value 3.
4. Overrun and set-wins: pulse req_i[1] twice while requester 0 busy → ovf_o=1 and only one job for requester 1. Pulse req_i[0] in its grant cycle → a second job for requester 0 runs.
5. Spurious done and reset: mul_done_strb_i in IDLE → no done_o. Deassert rstn_i during WAIT → outputs 0 immediately; no done_o after release.
6. MUL_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, multiplier never responds → done_o with err_o=1 and result_o=0 after 16 WAIT cycles; FSM returns to IDLE.
